run_detect_sched: RTL



---
 rtl/run_detect_sched_pkg.sv | 30 +++
 rtl/run_detect_sched_if.sv | 27 ++
 rtl/run_detect_sched_detector.sv | 50 +++++
 rtl/run_detect_sched.sv | 110 +++++++++++
 4 files changed

// File: rtl/run_detect_sched_pkg.sv
// Shared types and constants for the run detector scheduler.
// Detector codes A..I map to 0..8; codes 9..15 are unused.
package run_detect_sched_pkg;

    localparam int RUN_LEN = 4;

    typedef enum logic [3:0] {
        DET_A = 4'd0,
        DET_B = 4'd1,
        DET_C = 4'd2,
        DET_D = 4'd3,
        DET_E = 4'd4,
        DET_F = 4'd5,
        DET_G = 4'd6,
        DET_H = 4'd7,
        DET_I = 4'd8
    } det_state_t;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_RUN  = 2'd1,
        CTL_DONE = 2'd2
    } ctl_state_t;

    // E and I are the states reached after RUN_LEN equal bits
    function automatic logic det_is_match(logic [3:0] s);
        return (s == 4'(RUN_LEN)) || (s == 4'(2 * RUN_LEN));
    endfunction

endpackage

// File: rtl/run_detect_sched_if.sv
// Pattern/length request and status bundle of the scheduler.
// master drives the request, slave is the scheduler.
interface run_detect_sched_if #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 5
);
    logic             Start;
    logic [PAT_W-1:0] Pattern;
    logic [LEN_W-1:0] Length;
    logic             Busy;
    logic             Done;
    logic             W_out;
    logic             Z;
    logic [3:0]       Det_state;
    logic [CNT_W-1:0] Match_count;

    modport master (
        output Start, Pattern, Length,
        input  Busy, Done, W_out, Z, Det_state, Match_count
    );

    modport slave (
        input  Start, Pattern, Length,
        output Busy, Done, W_out, Z, Det_state, Match_count
    );
endinterface

// File: rtl/run_detect_sched_detector.sv
// Moore detector for four equal bits in a row.
// Clear wins over Step; state moves only on Step.
import run_detect_sched_pkg::*;

module run_detector (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Clear,
    input  logic       Step,
    input  logic       W,
    output logic [3:0] State,
    output logic [3:0] Next,
    output logic       Z
);
    logic [3:0] state_q;
    logic [3:0] nxt;

    // next-state table; unused codes fall back to A
    always_comb begin
        nxt = DET_A;
        case (state_q)
            DET_A: nxt = W ? DET_F : DET_B;
            DET_B: nxt = W ? DET_F : DET_C;
            DET_C: nxt = W ? DET_F : DET_D;
            DET_D: nxt = W ? DET_F : DET_E;
            DET_E: nxt = W ? DET_F : DET_E;
            DET_F: nxt = W ? DET_G : DET_B;
            DET_G: nxt = W ? DET_H : DET_B;
            DET_H: nxt = W ? DET_I : DET_B;
            DET_I: nxt = W ? DET_I : DET_B;
            default: nxt = DET_A;
        endcase
    end

    // state register with clear priority
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= DET_A;
        end else if (Clear) begin
            state_q <= DET_A;
        end else if (Step) begin
            state_q <= nxt;
        end
    end

    assign State = state_q;
    assign Next  = nxt;
    assign Z     = det_is_match(state_q);

endmodule

// File: rtl/run_detect_sched.sv
// Sequences a latched pattern through the run detector LSB first
// and counts detections for one Start/Done transaction.
import run_detect_sched_pkg::*;

module run_detect_sched #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 5
) (
    input logic Clock,
    input logic Reset,
    run_detect_sched_if.slave bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    ctl_state_t       st_q;
    logic             busy_q;
    logic             done_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;

    logic [LEN_W-1:0] len_clamp;
    logic             accept;
    logic             in_run;
    logic             last_bit;
    logic             w_bit;
    logic [3:0]       det_state;
    logic [3:0]       det_next;
    logic             det_z;

    assign len_clamp = (bus.Length > LEN_W'(PAT_W)) ?
                       LEN_W'(PAT_W) : bus.Length;
    assign accept    = (st_q == CTL_IDLE) && bus.Start;
    assign in_run    = (st_q == CTL_RUN);
    assign last_bit  = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign w_bit     = in_run ? pat_q[idx_q] : 1'b0;

    run_detector u_det (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (accept && (bus.Length != '0)),
        .Step  (in_run),
        .W     (w_bit),
        .State (det_state),
        .Next  (det_next),
        .Z     (det_z)
    );

    // controller FSM with registered status and match counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            st_q   <= CTL_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pat_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (st_q)
                CTL_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        cnt_q <= '0;
                        if (bus.Length != '0) begin
                            pat_q  <= bus.Pattern;
                            len_q  <= len_clamp;
                            idx_q  <= '0;
                            busy_q <= 1'b1;
                            st_q   <= CTL_RUN;
                        end else begin
                            done_q <= 1'b1;
                            st_q   <= CTL_DONE;
                        end
                    end
                end
                CTL_RUN: begin
                    idx_q <= idx_q + 1'b1;
                    if (det_is_match(det_next) && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (last_bit) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        st_q   <= CTL_DONE;
                    end
                end
                CTL_DONE: begin
                    done_q <= 1'b0;
                    st_q   <= CTL_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    st_q   <= CTL_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.W_out       = w_bit;
    assign bus.Z           = det_z;
    assign bus.Det_state   = det_state;
    assign bus.Match_count = cnt_q;

endmodule
